i_cache_2way: RTL

Two-way set-associative instruction cache with multi-word lines and a burst refill FSM. It sits between the fetch stage (p_* side) and the memory/AXI bridge (m_* side). Hits return data combinationally in the same cycle. Misses refill a whole line, one word per m_ready beat, then the access retries as a hit. Per-set LRU replacement and a whole-cache flush are included.

---
 rtl/i_cache_2way.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/i_cache_2way.sv
// Two-way set-associative instruction cache: zero-latency hits, per-set LRU,
// whole-line burst refill from memory and a flush that never aborts a burst.
module i_cache_2way #(
  parameter int A_WIDTH  = 32,
  parameter int C_INDEX  = 6,
  parameter int C_OFFSET = 2
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] p_a,
  input  logic               p_strobe,
  output logic [31:0]        p_din,
  output logic               p_ready,
  input  logic               p_flush,
  output logic [A_WIDTH-1:0] m_a,
  output logic               m_strobe,
  input  logic [31:0]        m_dout,
  input  logic               m_ready
);

  localparam int T_WIDTH = A_WIDTH - C_INDEX - C_OFFSET - 2;
  localparam int SETS    = 1 << C_INDEX;
  localparam int WORDS   = 1 << C_OFFSET;
  localparam int CW      = C_OFFSET + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(WORDS - 1);

  typedef enum logic {IDLE, REFILL} state_t;

  state_t state, state_next;

  logic [SETS-1:0]    valid0, valid1, lru;
  logic [T_WIDTH-1:0] tag0 [SETS];
  logic [T_WIDTH-1:0] tag1 [SETS];
  logic [31:0]        data0 [SETS][WORDS];
  logic [31:0]        data1 [SETS][WORDS];

  logic [A_WIDTH-1:0] base_a;
  logic               victim;
  logic [CW-1:0]      counter;
  logic               flush_pend;

  logic [T_WIDTH-1:0]  p_tag;
  logic [C_INDEX-1:0]  p_index;
  logic [C_OFFSET-1:0] p_offset;
  logic [T_WIDTH-1:0]  r_tag;
  logic [C_INDEX-1:0]  r_index;
  logic [C_OFFSET-1:0] r_word;
  logic                hit0, hit1, hit;
  logic                victim_sel, miss_start, beat, last_beat;
  logic [1:0]          unused_addr_bits;

  assign p_tag    = p_a[A_WIDTH-1:C_OFFSET+C_INDEX+2];
  assign p_index  = p_a[C_OFFSET+C_INDEX+1:C_OFFSET+2];
  assign p_offset = p_a[C_OFFSET+1:2];
  assign unused_addr_bits = p_a[1:0];

  // Refill side works only from the latched line base, so p_a may wander.
  assign r_tag   = base_a[A_WIDTH-1:C_OFFSET+C_INDEX+2];
  assign r_index = base_a[C_OFFSET+C_INDEX+1:C_OFFSET+2];
  assign r_word  = counter[C_OFFSET-1:0];

  assign hit0 = valid0[p_index] && (tag0[p_index] == p_tag);
  assign hit1 = valid1[p_index] && (tag1[p_index] == p_tag);
  assign hit  = hit0 || hit1;

  // An empty way is always filled first; only a full set consults the LRU bit.
  assign victim_sel = !valid0[p_index] ? 1'b0 :
                      !valid1[p_index] ? 1'b1 : lru[p_index];

  assign miss_start = (state == IDLE) && p_strobe && !hit;
  assign beat       = (state == REFILL) && m_ready;
  assign last_beat  = (counter == LAST_BEAT);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (miss_start) state_next = REFILL;
      REFILL:  if (beat && last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    p_ready  = 1'b0;
    m_strobe = 1'b0;
    p_din    = hit1 ? data1[p_index][p_offset] : data0[p_index][p_offset];
    m_a      = base_a + {{(A_WIDTH-CW-2){1'b0}}, counter, 2'b00};
    case (state)
      IDLE:    p_ready  = p_strobe && hit;
      REFILL:  m_strobe = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      base_a     <= '0;
      victim     <= 1'b0;
      counter    <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (miss_start) begin
        base_a  <= {p_a[A_WIDTH-1:C_OFFSET+2], {(C_OFFSET+2){1'b0}}};
        victim  <= victim_sel;
        counter <= '0;
      end else if (beat) begin
        counter <= counter + CW'(1);
      end
      if (state == REFILL) begin
        if (beat && last_beat) begin
          flush_pend <= 1'b0;
        end else if (p_flush) begin
          flush_pend <= 1'b1;
        end
      end
    end
  end

  // A flush seen during a burst, even on its final beat, leaves the line invalid.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else if (state == IDLE) begin
      if (p_strobe && hit) begin
        lru[p_index] <= ~hit1;
      end
      if (p_flush) begin
        valid0 <= '0;
        valid1 <= '0;
      end else if (miss_start) begin
        if (victim_sel) begin
          valid1[p_index] <= 1'b0;
        end else begin
          valid0[p_index] <= 1'b0;
        end
      end
    end else if (beat && last_beat) begin
      lru[r_index] <= ~victim;
      if (flush_pend || p_flush) begin
        valid0 <= '0;
        valid1 <= '0;
      end else if (victim) begin
        valid1[r_index] <= 1'b1;
      end else begin
        valid0[r_index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      if (victim) begin
        data1[r_index][r_word] <= m_dout;
      end else begin
        data0[r_index][r_word] <= m_dout;
      end
      if (last_beat) begin
        if (victim) begin
          tag1[r_index] <= r_tag;
        end else begin
          tag0[r_index] <= r_tag;
        end
      end
    end
  end

endmodule
